// File: rtl/muller_pkg.sv
// Shared definitions for the Muller C-element micropipeline: protocol
// selectors and the C-element update rule used by every stage.
package muller_pkg;

  // Handshake protocol selectors for the PROTO parameter.
  localparam int PROTO_4PH = 0;  // return-to-zero: one item per full req/ack cycle
  localparam int PROTO_2PH = 1;  // transition: every edge of req/ack is one token

  // C-element rule: when both inputs agree the output adopts their value,
  // otherwise it keeps its previous value.
  function automatic logic c_next(input logic a, input logic b, input logic q);
    return (a == b) ? a : q;
  endfunction

endpackage

// File: rtl/muller_c_pipeline_if.sv
// Producer/consumer channel bundle for the micropipeline.
//
// Handshake semantics (both ports, selected by PROTO of the pipeline):
//   4-phase: the producer presents in_data and raises in_req; in_ack rising
//            means the item was captured; in_req then returns to 0 and the
//            item is complete once in_ack returns to 0. The consumer side is
//            the mirror image with out_req/out_ack and out_data.
//   2-phase: every toggle of in_req offers one token (in_data held stable
//            until in_ack equals in_req again). An item is waiting for the
//            consumer whenever out_req != out_ack; toggling out_ack takes it.
//   in_data must be stable whenever in_req differs from in_ack.
interface muller_c_pipeline_if #(
  parameter int DATA_W = 8,
  parameter int OCC_W  = 3
);
  logic              in_req;
  logic              in_ack;
  logic [DATA_W-1:0] in_data;
  logic              out_req;
  logic              out_ack;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic              proto_err;

  // Environment side: drives the producer request/data and consumer ack.
  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, occupancy, proto_err
  );

  // Pipeline side.
  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, occupancy, proto_err
  );
endinterface

// File: rtl/muller_c_stage.sv
// One micropipeline stage: a clocked C-element control bit plus the data
// register bundled with it. The data register captures its predecessor's data
// whenever the control bit accepts a new item (rise for 4-phase, any toggle
// for 2-phase).
module muller_c_stage
  import muller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PROTO  = PROTO_4PH
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              prev_c,   // control of the stage before (or in_req)
  input  logic              next_c,   // control of the stage after (or out_ack)
  input  logic [DATA_W-1:0] prev_d,   // data of the stage before (or in_data)
  output logic              c_o,
  output logic [DATA_W-1:0] d_o
);

  logic              c_q;
  logic              c_d;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] d_d;
  logic              capture;

  // Next control bit from the C-element rule and the matching data capture.
  always_comb begin
    c_d     = c_next(prev_c, ~next_c, c_q);
    capture = 1'b0;
    if (PROTO == PROTO_2PH) begin
      capture = c_d ^ c_q;
    end else begin
      capture = c_d & ~c_q;
    end
    d_d = capture ? prev_d : d_q;
  end

  // Control and data registers, cleared by synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      c_q <= 1'b0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  assign c_o = c_q;
  assign d_o = d_q;

endmodule

// File: rtl/muller_c_pipeline.sv
// Clocked Muller C-element micropipeline: DEPTH chained C-element stages with
// bundled data, 4-phase or 2-phase handshaking, combinational occupancy and a
// sticky producer-protocol checker. Every stage reads only registered
// neighbour state, so no combinational path exists from inputs to req/ack.
module muller_c_pipeline
  import muller_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  parameter  int PROTO  = PROTO_4PH,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_req,
  output logic              in_ack,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_req,
  input  logic              out_ack,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic              proto_err
);

  logic [DEPTH-1:0]  c;
  logic [DATA_W-1:0] d [DEPTH];

  // Stage chain: stage 0 sees in_req/in_data, the last stage sees out_ack.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              pc;
    logic              nc;
    logic [DATA_W-1:0] pd;

    if (i == 0) begin : g_first
      assign pc = in_req;
      assign pd = in_data;
    end else begin : g_mid
      assign pc = c[i-1];
      assign pd = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign nc = out_ack;
    end else begin : g_inner
      assign nc = c[i+1];
    end

    muller_c_stage #(
      .DATA_W (DATA_W),
      .PROTO  (PROTO)
    ) u_stage (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .prev_c   (pc),
      .next_c   (nc),
      .prev_d   (pd),
      .c_o      (c[i]),
      .d_o      (d[i])
    );
  end

  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = d[DEPTH-1];

  // Occupancy: control vector extended with out_ack as the stage past the end.
  // 4-phase counts item heads (1 followed by 0); 2-phase counts boundaries.
  logic [DEPTH:0]   c_ext;
  logic [OCC_W-1:0] occ_sum;

  assign c_ext = {out_ack, c};

  // Count occupied positions along the chain.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PROTO == PROTO_2PH) begin
        occ_sum = occ_sum + OCC_W'(c_ext[k] ^ c_ext[k+1]);
      end else begin
        occ_sum = occ_sum + OCC_W'(c_ext[k] & ~c_ext[k+1]);
      end
    end
  end

  assign occupancy = occ_sum;

  // Producer protocol checker: a change of in_req while the previous request
  // is still unacknowledged (req_q != in_ack) is a violation. A request held
  // through reset release looks like a fresh edge with req_q == in_ack == 0,
  // so it is not flagged.
  logic req_q;
  logic req_d;
  logic err_q;
  logic err_d;

  // Next-state for the request copy and the sticky error flag.
  always_comb begin
    req_d = in_req;
    err_d = err_q | ((in_req != req_q) && (req_q != c[0]));
  end

  // Checker registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      err_q <= err_d;
    end
  end

  assign proto_err = err_q;

endmodule
